sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 92 +++++++++
 tb/tb_sw_debounce.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Nine-channel switch debouncer: two-flop synchroniser and a saturating-free
// run counter per channel, plus a shared update pulse and event counter.
module sw_debounce #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       sw_en,
    output logic [7:0] x,
    output logic       en,
    output logic       changed,
    output logic [7:0] change_cnt
);
    localparam int NCH = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] db;
    logic [NCH-1:0] accept;
    logic           changed_reg;
    logic [7:0]     change_cnt_reg;

    // Channel 8 is the enable switch; it is handled exactly like the data bits.
    assign raw = {sw_en, sw};

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic             db_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             hit;

            // Counter only runs while the synchronised input disagrees; the
            // accept edge reloads 0 so the count can never pass CNT_LAST.
            always_comb begin
                db_next  = db_reg;
                cnt_next = '0;
                hit      = 1'b0;
                if (s2_reg != db_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        db_next = s2_reg;
                        hit     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg  <= raw[gi];
                    s2_reg  <= s1_reg;
                    db_reg  <= db_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign db[gi]     = db_reg;
            assign accept[gi] = hit;
        end
    endgenerate

    // One event per edge regardless of how many channels accepted together.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_reg    <= 1'b0;
            change_cnt_reg <= 8'd0;
        end else begin
            changed_reg <= |accept;
            if (|accept) begin
                change_cnt_reg <= change_cnt_reg + 8'd1;
            end
        end
    end

    assign x          = db[7:0];
    assign en         = db[8];
    assign changed    = changed_reg;
    assign change_cnt = change_cnt_reg;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce (DB_CYCLES=4) against a
// window-based reference model of the acceptance rule.
module tb_sw_debounce;
    localparam int DB   = 4;
    localparam int HMAX = 16384;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       sw_en;
    logic [7:0] x;
    logic       en;
    logic       changed;
    logic [7:0] change_cnt;

    sw_debounce #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .sw_en(sw_en),
        .x(x),
        .en(en),
        .changed(changed),
        .change_cnt(change_cnt)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference state: raw history per edge, accepted values, last accept/reset edge.
    logic [8:0] hist [0:HMAX-1];
    int         n = 0;
    logic [8:0] m_db = '0;
    int         m_since [9];
    logic       m_chg = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp)
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        else
            pass_cnt++;
    endtask

    // A channel accepts on edge n when the synchronised value (raw from two
    // edges earlier) differed from its debounced value on each of the last DB
    // edges, all after its most recent reset or accept.
    task automatic model_edge(input logic [8:0] r, input logic rr);
        logic any;
        logic ok;
        logic seen;
        int   m;
        any = 1'b0;
        hist[n] = rr ? 9'd0 : r;
        for (int c = 0; c < 9; c++) begin
            if (rr) begin
                m_db[c]    = 1'b0;
                m_since[c] = n;
            end else begin
                ok = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    m = n - j;
                    seen = (m >= 2) ? hist[m-2][c] : 1'b0;
                    if (m <= m_since[c] || seen == m_db[c]) ok = 1'b0;
                end
                if (ok) begin
                    m_db[c]    = ~m_db[c];
                    m_since[c] = n;
                    any        = 1'b1;
                end
            end
        end
        if (rr) begin
            m_chg = 1'b0;
            m_cnt = 8'd0;
        end else begin
            m_chg = any;
            if (any) m_cnt = m_cnt + 8'd1;
        end
        n++;
    endtask

    task automatic step(input logic [7:0] s, input logic e, input logic r);
        sw    = s;
        sw_en = e;
        rst   = r;
        @(posedge clk);
        model_edge({e, s}, r);
        #1;
        check("x", {24'd0, x}, {24'd0, m_db[7:0]});
        check("en", {31'd0, en}, {31'd0, m_db[8]});
        check("changed", {31'd0, changed}, {31'd0, m_chg});
        check("change_cnt", {24'd0, change_cnt}, {24'd0, m_cnt});
    endtask

    task automatic settle(input logic [7:0] s, input logic e, input int cycles);
        for (int i = 0; i < cycles; i++) step(s, e, 1'b0);
    endtask

    initial begin
        logic [7:0] c0;
        int         tx;
        int         te;
        int         pulses;
        int         hit_edge;
        logic       lvl;
        logic       seq [20];
        logic [8:0] r9;
        logic       rr;
        int         t;
        int         len;

        clk = 1'b0; rst = 1'b1; sw = 8'd0; sw_en = 1'b0;
        for (int c = 0; c < 9; c++) m_since[c] = 0;

        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
        check("reset_x", {24'd0, x}, 32'd0);
        check("reset_cnt", {24'd0, change_cnt}, 32'd0);

        // Clean press
        step(8'h05, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) step(8'h05, 1'b0, 1'b0);
        check("press_early", {24'd0, x}, 32'h00);
        step(8'h05, 1'b0, 1'b0);
        check("press_x", {24'd0, x}, 32'h05);
        check("press_chg", {31'd0, changed}, 32'd1);
        check("press_cnt", {24'd0, change_cnt}, 32'd1);
        step(8'h05, 1'b0, 1'b0);
        check("press_chg_off", {31'd0, changed}, 32'd0);
        settle(8'h00, 1'b0, 8);

        // Glitch on sw[3]
        c0 = m_cnt;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(8'h08, 1'b0, 1'b0);
            if (changed) pulses++;
        end
        for (int i = 0; i < 8; i++) begin
            step(8'h00, 1'b0, 1'b0);
            if (changed) pulses++;
        end
        check("glitch_x", {24'd0, x}, 32'h00);
        check("glitch_pulses", pulses, 0);
        check("glitch_cnt", {24'd0, change_cnt}, {24'd0, c0});

        // All channels at once
        c0 = m_cnt; tx = -1; te = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b1, 1'b0);
            if (changed) pulses++;
            if (tx < 0 && x == 8'hFF) tx = i;
            if (te < 0 && en) te = i;
        end
        check("simul_x_edge", tx, 5);
        check("simul_en_edge", te, 5);
        check("simul_pulses", pulses, 1);
        check("simul_cnt", {24'd0, change_cnt}, {24'd0, c0 + 8'd1});
        settle(8'h00, 1'b0, 8);

        // Reset in the middle of a count
        for (int i = 0; i < 4; i++) step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b1);
        step(8'h01, 1'b0, 1'b1);
        check("rstmid_x", {24'd0, x}, 32'd0);
        check("rstmid_chg", {31'd0, changed}, 32'd0);
        check("rstmid_cnt", {24'd0, change_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(8'h01, 1'b0, 1'b0);
            if (i < 5) check("rstmid_hold", {24'd0, x}, 32'h00);
        end
        check("rstmid_accept", {24'd0, x}, 32'h01);
        check("rstmid_chg2", {31'd0, changed}, 32'd1);
        check("rstmid_cnt2", {24'd0, change_cnt}, 32'd1);
        settle(8'h00, 1'b0, 8);

        // 256 clean toggles of sw[1]
        c0 = m_cnt; lvl = 1'b0;
        for (int k = 0; k < 256; k++) begin
            lvl = ~lvl;
            settle({6'd0, lvl, 1'b0}, 1'b0, 6);
            check("wrap_x1", {31'd0, x[1]}, {31'd0, lvl});
        end
        check("wrap_cnt", {24'd0, change_cnt}, {24'd0, c0});
        settle(8'h00, 1'b0, 4);

        // Bounce on sw[6], then hold high
        t = 0; lvl = 1'b1;
        while (t < 20) begin
            len = $urandom_range(1, 2);
            for (int i = 0; i < len; i++) begin
                if (t < 20) seq[t] = lvl;
                t++;
            end
            lvl = ~lvl;
        end
        seq[19] = 1'b0;
        pulses = 0; hit_edge = -1;
        for (int i = 0; i < 30; i++) begin
            step((i < 20) ? {1'b0, seq[i], 6'd0} : 8'h40, 1'b0, 1'b0);
            if (changed) begin
                pulses++;
                hit_edge = i;
            end
        end
        check("bounce_pulses", pulses, 1);
        check("bounce_edge", hit_edge, 25);
        check("bounce_x", {24'd0, x}, 32'h40);

        // Random traffic with occasional resets
        r9 = {en, 8'h40};
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 9; c++)
                if ($urandom_range(0, 9) == 0) r9[c] = ~r9[c];
            rr = ($urandom_range(0, 199) == 0);
            step(r9[7:0], r9[8], rr);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
